// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the data-memory arbiter: FSM states and owner codes.
package dmem_arb_pkg;

    localparam int unsigned ST_W  = 2;
    localparam int unsigned OWN_W = 2;

    localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [ST_W-1:0] ST_ISSUE = 2'd1;
    localparam logic [ST_W-1:0] ST_WAIT  = 2'd2;
    localparam logic [ST_W-1:0] ST_RESP  = 2'd3;

    localparam logic [OWN_W-1:0] OWN_NONE = 2'd0;
    localparam logic [OWN_W-1:0] OWN_CPU  = 2'd1;
    localparam logic [OWN_W-1:0] OWN_DMA  = 2'd2;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the CPU port, the DMA port, the memory and the arbiter.
interface dmem_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) ();
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;
    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_ack;
    logic [DW-1:0] dma_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [1:0]    owner;

    // Arbiter view
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        input  mem_rdata,
        output cpu_ack, cpu_rdata, cpu_stall,
        output dma_ack, dma_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output owner
    );

    // Requesters plus memory view
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        output mem_rdata,
        input  cpu_ack, cpu_rdata, cpu_stall,
        input  dma_ack, dma_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  owner
    );
endinterface

// File: rtl/dmem_arb_fair.sv
// Bounded-priority winner select: CPU wins ties until it has taken
// MAX_CPU_BURST consecutive grants while DMA was waiting.
module dmem_arb_fair
    import dmem_arb_pkg::*;
#(
    parameter int unsigned MAX_CPU_BURST = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cpu_req,
    input  logic             dma_req,
    input  logic             grant,
    output logic [OWN_W-1:0] winner
);
    localparam int unsigned SW = $clog2(MAX_CPU_BURST + 1);

    logic [SW-1:0] streak_q;
    logic [SW-1:0] streak_d;

    // Winner select and next streak value
    always_comb begin
        winner   = OWN_NONE;
        streak_d = streak_q;
        if (cpu_req && dma_req) begin
            winner = (streak_q >= SW'(MAX_CPU_BURST)) ? OWN_DMA : OWN_CPU;
        end else if (dma_req) begin
            winner = OWN_DMA;
        end else if (cpu_req) begin
            winner = OWN_CPU;
        end
        if (grant) begin
            if (winner == OWN_CPU && dma_req) begin
                streak_d = (streak_q >= SW'(MAX_CPU_BURST)) ? streak_q : streak_q + SW'(1);
            end else begin
                streak_d = '0;
            end
        end
    end

    // Streak register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end
endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter between the pipeline and a DMA/loader port.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned AW            = 32,
    parameter int unsigned DW            = 32,
    parameter int unsigned RD_LAT        = 1,
    parameter int unsigned MAX_CPU_BURST = 4
) (
    input logic           clock,
    input logic           reset,
    dmem_arbiter_if.slave bus
);
    localparam int unsigned CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    logic [ST_W-1:0]  state_q, state_d;
    logic [OWN_W-1:0] owner_q, owner_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic             we_q, we_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             mem_en_q, mem_we_q;
    logic             cpu_ack_q, dma_ack_q;
    logic             grant;
    logic [OWN_W-1:0] winner;

    dmem_arb_fair #(
        .MAX_CPU_BURST(MAX_CPU_BURST)
    ) u_fair (
        .clock  (clock),
        .reset  (reset),
        .cpu_req(bus.cpu_req),
        .dma_req(bus.dma_req),
        .grant  (grant),
        .winner (winner)
    );

    // Next-state, request latch and read capture
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        grant   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                owner_d = OWN_NONE;
                if (bus.cpu_req || bus.dma_req) begin
                    grant   = 1'b1;
                    owner_d = winner;
                    state_d = ST_ISSUE;
                    if (winner == OWN_DMA) begin
                        addr_d  = bus.dma_addr;
                        wdata_d = bus.dma_wdata;
                        we_d    = bus.dma_we;
                    end else begin
                        addr_d  = bus.cpu_addr;
                        wdata_d = bus.cpu_wdata;
                        we_d    = bus.cpu_we;
                    end
                end
            end
            ST_ISSUE: begin
                if (we_q) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = CW'(RD_LAT - 1);
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    rdata_d = bus.mem_rdata;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_RESP: begin
                owner_d = OWN_NONE;
                state_d = ST_IDLE;
            end
            default: begin
                owner_d = OWN_NONE;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered strobes
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_NONE;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            rdata_q   <= '0;
            cnt_q     <= '0;
            mem_en_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            cpu_ack_q <= 1'b0;
            dma_ack_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            rdata_q   <= rdata_d;
            cnt_q     <= cnt_d;
            mem_en_q  <= (state_d == ST_ISSUE);
            mem_we_q  <= (state_d == ST_ISSUE) && we_d;
            cpu_ack_q <= (state_d == ST_RESP) && (owner_d == OWN_CPU);
            dma_ack_q <= (state_d == ST_RESP) && (owner_d == OWN_DMA);
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.dma_ack   = dma_ack_q;
    assign bus.cpu_rdata = rdata_q;
    assign bus.dma_rdata = rdata_q;
    assign bus.owner     = owner_q;
    assign bus.cpu_stall = bus.cpu_req & ~bus.cpu_ack;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter (RD_LAT=1 and RD_LAT=3 instances).
module tb_dmem_arbiter;
    logic clock;
    logic reset;
    int   checks;
    int   errors;

    localparam logic [31:0] JUNK = 32'hFFFF_FFFF;

    dmem_arbiter_if #(.AW(32), .DW(32)) bus  ();
    dmem_arbiter_if #(.AW(32), .DW(32)) bus3 ();

    dmem_arbiter #(.AW(32), .DW(32), .RD_LAT(1), .MAX_CPU_BURST(4)) u_dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    dmem_arbiter #(.AW(32), .DW(32), .RD_LAT(3), .MAX_CPU_BURST(4)) u_dut3 (
        .clock(clock),
        .reset(reset),
        .bus  (bus3.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++; if (bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_strobe: got en=%b we=%b want 0 0", bus.mem_en, bus.mem_we); end
        checks++; if (bus.cpu_ack !== 1'b0 || bus.dma_ack !== 1'b0) begin errors++; $display("FAIL reset_acks: got %b %b want 0 0", bus.cpu_ack, bus.dma_ack); end
        checks++; if (bus.owner !== 2'd0) begin errors++; $display("FAIL reset_owner: got %0d want 0", bus.owner); end
        checks++; if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_bus: got %h %h want 0 0", bus.mem_addr, bus.mem_wdata); end
        checks++; if (bus.cpu_rdata !== 32'h0 || bus.dma_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h %h want 0 0", bus.cpu_rdata, bus.dma_rdata); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_cpu_write();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h10; bus.cpu_wdata = 32'hDEAD_BEEF;
        #1;
        checks++; if (bus.cpu_stall !== 1'b1 || bus.owner !== 2'd0 || bus.mem_en !== 1'b0) begin errors++; $display("FAIL wr_c0: got stall=%b owner=%0d en=%b want 1 0 0", bus.cpu_stall, bus.owner, bus.mem_en); end
        step();
        checks++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1) begin errors++; $display("FAIL wr_c1_strobe: got en=%b we=%b want 1 1", bus.mem_en, bus.mem_we); end
        checks++; if (bus.mem_addr !== 32'h10 || bus.mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_c1_bus: got %h %h want 00000010 deadbeef", bus.mem_addr, bus.mem_wdata); end
        checks++; if (bus.owner !== 2'd1 || bus.cpu_stall !== 1'b1 || bus.cpu_ack !== 1'b0) begin errors++; $display("FAIL wr_c1_ctl: got owner=%0d stall=%b ack=%b want 1 1 0", bus.owner, bus.cpu_stall, bus.cpu_ack); end
        step();
        checks++; if (bus.cpu_ack !== 1'b1 || bus.cpu_stall !== 1'b0 || bus.dma_ack !== 1'b0) begin errors++; $display("FAIL wr_c2_ack: got ack=%b stall=%b dack=%b want 1 0 0", bus.cpu_ack, bus.cpu_stall, bus.dma_ack); end
        checks++; if (bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL wr_c2_strobe: got en=%b we=%b want 0 0", bus.mem_en, bus.mem_we); end
        bus.cpu_req = 1'b0;
        step();
        checks++; if (bus.cpu_ack !== 1'b0 || bus.owner !== 2'd0) begin errors++; $display("FAIL wr_c3_idle: got ack=%b owner=%0d want 0 0", bus.cpu_ack, bus.owner); end
    endtask

    task automatic test_cpu_read();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h20; bus.cpu_wdata = 32'h0;
        step();
        checks++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.owner !== 2'd1 || bus.mem_addr !== 32'h20) begin errors++; $display("FAIL rd_c1: got en=%b we=%b owner=%0d addr=%h want 1 0 1 00000020", bus.mem_en, bus.mem_we, bus.owner, bus.mem_addr); end
        step();
        bus.mem_rdata = 32'h1234_5678;
        checks++; if (bus.cpu_ack !== 1'b0 || bus.owner !== 2'd1 || bus.mem_en !== 1'b0) begin errors++; $display("FAIL rd_c2: got ack=%b owner=%0d en=%b want 0 1 0", bus.cpu_ack, bus.owner, bus.mem_en); end
        step();
        bus.mem_rdata = JUNK;
        checks++; if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== 32'h1234_5678 || bus.owner !== 2'd1) begin errors++; $display("FAIL rd_c3: got ack=%b rdata=%h owner=%0d want 1 12345678 1", bus.cpu_ack, bus.cpu_rdata, bus.owner); end
        bus.cpu_req = 1'b0;
        step();
        checks++; if (bus.cpu_ack !== 1'b0 || bus.owner !== 2'd0) begin errors++; $display("FAIL rd_c4: got ack=%b owner=%0d want 0 0", bus.cpu_ack, bus.owner); end
    endtask

    task automatic test_read_lat3();
        bus3.cpu_req = 1'b1; bus3.cpu_we = 1'b0; bus3.cpu_addr = 32'h24;
        step();
        checks++; if (bus3.mem_en !== 1'b1 || bus3.mem_addr !== 32'h24) begin errors++; $display("FAIL rd3_c1: got en=%b addr=%h want 1 00000024", bus3.mem_en, bus3.mem_addr); end
        for (int c = 2; c <= 4; c++) begin
            step();
            if (c == 4) bus3.mem_rdata = 32'hCAFE_F00D;
            checks++; if (bus3.cpu_ack !== 1'b0 || bus3.owner !== 2'd1) begin errors++; $display("FAIL rd3_wait_c%0d: got ack=%b owner=%0d want 0 1", c, bus3.cpu_ack, bus3.owner); end
        end
        step();
        bus3.mem_rdata = JUNK;
        checks++; if (bus3.cpu_ack !== 1'b1 || bus3.cpu_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL rd3_c5: got ack=%b rdata=%h want 1 cafef00d", bus3.cpu_ack, bus3.cpu_rdata); end
        bus3.cpu_req = 1'b0;
        step();
    endtask

    task automatic test_simultaneous();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h30; bus.cpu_wdata = 32'h3333_3333;
        bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 32'h40; bus.dma_wdata = 32'h4444_4444;
        step();
        checks++; if (bus.owner !== 2'd1 || bus.mem_addr !== 32'h30) begin errors++; $display("FAIL sim_c1: got owner=%0d addr=%h want 1 00000030", bus.owner, bus.mem_addr); end
        step();
        checks++; if (bus.cpu_ack !== 1'b1 || bus.dma_ack !== 1'b0) begin errors++; $display("FAIL sim_c2: got cack=%b dack=%b want 1 0", bus.cpu_ack, bus.dma_ack); end
        bus.cpu_req = 1'b0;
        step();
        checks++; if (bus.owner !== 2'd0 || bus.dma_ack !== 1'b0) begin errors++; $display("FAIL sim_c3: got owner=%0d dack=%b want 0 0", bus.owner, bus.dma_ack); end
        step();
        checks++; if (bus.owner !== 2'd2 || bus.mem_addr !== 32'h40 || bus.mem_wdata !== 32'h4444_4444 || bus.mem_we !== 1'b1) begin errors++; $display("FAIL sim_c4: got owner=%0d addr=%h wdata=%h we=%b want 2 00000040 44444444 1", bus.owner, bus.mem_addr, bus.mem_wdata, bus.mem_we); end
        step();
        checks++; if (bus.dma_ack !== 1'b1 || bus.cpu_ack !== 1'b0 || bus.dma_rdata !== 32'h1234_5678) begin errors++; $display("FAIL sim_c5: got dack=%b cack=%b rdata=%h want 1 0 12345678", bus.dma_ack, bus.cpu_ack, bus.dma_rdata); end
        bus.dma_req = 1'b0;
        step();
    endtask

    task automatic test_fairness();
        logic [1:0]  exp_owner;
        logic [31:0] exp_addr;
        int          waited;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h100; bus.cpu_wdata = 32'h1;
        bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 32'h200; bus.dma_wdata = 32'h2;
        for (int t = 0; t < 10; t++) begin
            waited = 0;
            while (bus.mem_en !== 1'b1 && waited < 10) begin
                step();
                waited++;
            end
            exp_owner = (t == 4 || t == 9) ? 2'd2 : 2'd1;
            exp_addr  = (t == 4 || t == 9) ? 32'h200 : 32'h100;
            checks++; if (bus.mem_en !== 1'b1 || bus.owner !== exp_owner || bus.mem_addr !== exp_addr) begin errors++; $display("FAIL fair_grant%0d: got en=%b owner=%0d addr=%h want 1 %0d %h", t, bus.mem_en, bus.owner, bus.mem_addr, exp_owner, exp_addr); end
            step();
        end
        bus.cpu_req = 1'b0;
        bus.dma_req = 1'b0;
        step();
        step();
    endtask

    task automatic test_withdrawal();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h50;
        step();
        step();
        bus.cpu_req   = 1'b0;
        bus.mem_rdata = 32'h55AA_33CC;
        step();
        bus.mem_rdata = JUNK;
        checks++; if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== 32'h55AA_33CC || bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL wd_ack: got ack=%b rdata=%h stall=%b want 1 55aa33cc 0", bus.cpu_ack, bus.cpu_rdata, bus.cpu_stall); end
        step();
        step();
        checks++; if (bus.owner !== 2'd0 || bus.mem_en !== 1'b0 || bus.cpu_ack !== 1'b0) begin errors++; $display("FAIL wd_idle: got owner=%0d en=%b ack=%b want 0 0 0", bus.owner, bus.mem_en, bus.cpu_ack); end
    endtask

    task automatic test_reset_mid_dma();
        bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 32'h80;
        step();
        step();
        checks++; if (bus.owner !== 2'd2) begin errors++; $display("FAIL rst_pre_owner: got %0d want 2", bus.owner); end
        reset = 1'b1;
        #1;
        checks++; if (bus.mem_en !== 1'b0 || bus.owner !== 2'd0 || bus.dma_ack !== 1'b0 || bus.mem_addr !== 32'h0 || bus.dma_rdata !== 32'h0) begin errors++; $display("FAIL rst_mid: got en=%b owner=%0d dack=%b addr=%h rdata=%h want 0 0 0 0 0", bus.mem_en, bus.owner, bus.dma_ack, bus.mem_addr, bus.dma_rdata); end
        step();
        step();
        checks++; if (bus.dma_ack !== 1'b0 || bus.owner !== 2'd0) begin errors++; $display("FAIL rst_hold: got dack=%b owner=%0d want 0 0", bus.dma_ack, bus.owner); end
        reset = 1'b0;
        step();
        checks++; if (bus.owner !== 2'd2 || bus.mem_en !== 1'b1 || bus.mem_addr !== 32'h80) begin errors++; $display("FAIL rst_reissue: got owner=%0d en=%b addr=%h want 2 1 00000080", bus.owner, bus.mem_en, bus.mem_addr); end
        step();
        bus.mem_rdata = 32'h7766_5544;
        step();
        bus.mem_rdata = JUNK;
        checks++; if (bus.dma_ack !== 1'b1 || bus.dma_rdata !== 32'h7766_5544 || bus.cpu_ack !== 1'b0) begin errors++; $display("FAIL rst_resp: got dack=%b rdata=%h cack=%b want 1 77665544 0", bus.dma_ack, bus.dma_rdata, bus.cpu_ack); end
        bus.dma_req = 1'b0;
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;
        bus.mem_rdata = JUNK;
        bus3.cpu_req = 1'b0; bus3.cpu_we = 1'b0; bus3.cpu_addr = '0; bus3.cpu_wdata = '0;
        bus3.dma_req = 1'b0; bus3.dma_we = 1'b0; bus3.dma_addr = '0; bus3.dma_wdata = '0;
        bus3.mem_rdata = JUNK;
        test_reset();
        test_cpu_write();
        test_cpu_read();
        test_read_lat3();
        test_simultaneous();
        test_fairness();
        test_withdrawal();
        test_reset_mid_dma();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
